// File: rtl/io_tx_port.sv
// io_tx_port: bus-mapped 12-bit serial transmitter with a 4-entry FIFO and status register.
// Ports: iCLK system clock, iRESETn async active-low reset;
//        iADDR/iDATA/iCSELn/iWR_ENn processor bus (shared with memory);
//        oDATA status read data (zero when not selected), oSEL address-decode hit,
//        oTXD serial line (idle high), oBUSY high while a frame is in progress.
module io_tx_port #(
   parameter logic [11:0] TX_ADDR      = 12'o7770,
   parameter logic [11:0] STAT_ADDR    = 12'o7771,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic        iCLK,
   input  logic        iRESETn,
   input  logic [11:0] iADDR,
   input  logic [11:0] iDATA,
   input  logic        iCSELn,
   input  logic        iWR_ENn,
   output logic [11:0] oDATA,
   output logic        oSEL,
   output logic        oTXD,
   output logic        oBUSY
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

   state_t      state_q, state_d;
   logic [7:0]  baud_q, baud_d;
   logic [3:0]  bit_q, bit_d;
   logic [11:0] shift_q, shift_d;
   logic        txd_q, txd_d, busy_q, busy_d;
   logic        wr_q, rd_q, ovf_q, ovf_d;
   logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [11:0] mem_q [4];
   logic        wr_c, rd_c, push, pop, push_ok, baud_end, full, empty;

   assign wr_c     = !iCSELn && !iWR_ENn && iADDR == TX_ADDR;
   assign rd_c     = !iCSELn && iWR_ENn && iADDR == STAT_ADDR;
   // a held write strobe only pushes on its first cycle
   assign push     = wr_c && !wr_q;
   assign full     = cnt_q == 3'd4;
   assign empty    = cnt_q == 3'd0;
   assign baud_end = baud_q == BAUD_LAST;
   // the serializer pops when idle, or on the last STOP cycle for back-to-back frames
   assign pop      = !empty && (state_q == IDLE || (state_q == STOP && baud_end));
   // a pop in the same cycle frees the slot a push at full needs
   assign push_ok  = push && (!full || pop);
   assign oSEL     = !iCSELn && (iADDR == TX_ADDR || iADDR == STAT_ADDR);
   assign oDATA    = rd_c ? {5'b0, ovf_q, cnt_q, busy_q, empty, full} : 12'o0000;
   assign oTXD     = txd_q;
   assign oBUSY    = busy_q;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      baud_d  = (state_q == IDLE || baud_end) ? 8'd0 : baud_q + 8'd1;
      case (state_q)
         IDLE:  if (pop) begin
            state_d = START;
            shift_d = mem_q[rptr_q];
         end
         START: if (baud_end) begin
            state_d = DATA;
            bit_d   = 4'd0;
         end
         DATA:  if (baud_end) begin
            shift_d = shift_q >> 1;
            bit_d   = (bit_q == 4'd11) ? 4'd0 : bit_q + 4'd1;
            state_d = (bit_q == 4'd11) ? STOP : DATA;
         end
         STOP:  if (baud_end) begin
            state_d = pop ? START : IDLE;
            shift_d = pop ? mem_q[rptr_q] : shift_q;
         end
      endcase
      // outputs are registered from the next state so they change with it
      txd_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
      busy_d = state_d != IDLE;
      wptr_d = push_ok ? wptr_q + 2'd1 : wptr_q;
      rptr_d = pop ? rptr_q + 2'd1 : rptr_q;
      cnt_d  = cnt_q + {2'b0, push_ok} - {2'b0, pop};
      // a dropped push outranks the clear from a status read on the same edge
      ovf_d  = (push && !push_ok) ? 1'b1 : (rd_c && !rd_q) ? 1'b0 : ovf_q;
   end

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state_q <= IDLE;
         baud_q  <= 8'd0;
         bit_q   <= 4'd0;
         shift_q <= 12'd0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         ovf_q   <= 1'b0;
         wptr_q  <= 2'd0;
         rptr_q  <= 2'd0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         wr_q    <= wr_c;
         rd_q    <= rd_c;
         ovf_q   <= ovf_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge iCLK) begin
      if (push_ok) mem_q[wptr_q] <= iDATA;
   end
endmodule
